// File: rtl/vga_1bit_scanout_if.sv
// vga_1bit_scanout_if: read port of the show-ahead pixel FIFO.
// master = FIFO side, slave = scanout side.
interface vga_1bit_scanout_if;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;

    modport master (
        output fifo_q,
        output fifo_empty,
        input  fifo_rdreq
    );

    modport slave (
        input  fifo_q,
        input  fifo_empty,
        output fifo_rdreq
    );
endinterface

// File: rtl/vga_1bit_scanout.sv
// vga_1bit_scanout: pops 16-bit FIFO words, shifts them out MSB-first as pixels.
// Define VGA_SCAN_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module vga_1bit_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    vga_1bit_scanout_if.slave  fifo,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_pixel,
    output logic               vblank_start,
    output logic               underflow
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]        underflow_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [15:0]   shreg;
    logic [15:0]   shreg_nxt;
    logic          enable_q;

    logic          pe;
    logic          run;
    logic          step;
    logic          h_last;
    logic          v_last;
    logic          frame_end;
    logic          in_active;
    logic          in_hs;
    logic          in_vs;
    logic          vb_hit;
    logic          load;
    logic          pop;
    logic          uf_hit;
    logic          uf_clr;

    // Pixel enable: one clk in every CLK_DIV, free-running
    assign pe = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (pe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (pe && frame_end && !enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run       = (state == RUN);
        step      = run && pe;
        h_last    = (int'(h_cnt) == H_TOTAL - 1);
        v_last    = (int'(v_cnt) == V_TOTAL - 1);
        frame_end = h_last && v_last;
        in_active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        in_hs     = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
        in_vs     = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);
        vb_hit    = (int'(v_cnt) == V_ACTIVE) && (h_cnt == '0);
        load      = step && in_active && (h_cnt[3:0] == 4'd0);
        pop       = load && !fifo.fifo_empty;
        uf_hit    = load && fifo.fifo_empty;
        uf_clr    = enable && !enable_q;
    end

    // A starved load shifts out zeros for the whole word
    always_comb begin
        shreg_nxt = {shreg[14:0], 1'b0};
        if (load) begin
            shreg_nxt = fifo.fifo_empty ? 16'h0000 : fifo.fifo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo.fifo_rdreq <= 1'b0;
            vga_hs          <= ~HS_POL;
            vga_vs          <= ~VS_POL;
            vga_pixel       <= 1'b0;
            vblank_start    <= 1'b0;
            underflow       <= 1'b0;
            shreg           <= 16'h0000;
            enable_q        <= 1'b0;
        end else begin
            enable_q        <= enable;
            fifo.fifo_rdreq <= pop;
            vblank_start    <= step && vb_hit;
            if (!run) begin
                vga_hs    <= ~HS_POL;
                vga_vs    <= ~VS_POL;
                vga_pixel <= 1'b0;
            end else if (pe) begin
                vga_hs    <= in_hs ? HS_POL : ~HS_POL;
                vga_vs    <= in_vs ? VS_POL : ~VS_POL;
                vga_pixel <= in_active && shreg_nxt[15];
                if (in_active) begin
                    shreg <= shreg_nxt;
                end
            end
            if (uf_clr) begin
                underflow <= 1'b0;
            end
            if (uf_hit) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_cnt <= 16'h0000;
        end else if (uf_clr && uf_hit) begin
            underflow_cnt <= 16'h0001;
        end else if (uf_clr) begin
            underflow_cnt <= 16'h0000;
        end else if (uf_hit && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_vga_1bit_scanout.sv
// tb_vga_1bit_scanout: directed tables plus random stimulus against a frame-time model.
// DUT a: CLK_DIV=1 fed from a queue FIFO; DUT b: CLK_DIV=2 fed a fixed word.
`timescale 1ns/1ps
module tb_vga_1bit_scanout;

    localparam int HA = 32, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam logic [15:0] PAT = 16'hA5F0;

    typedef struct {
        int v;
        int h;
        int pix;
        int hs;
        int vs;
        int rd;
        int vb;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    always #5 clk = ~clk;

    vga_1bit_scanout_if fa ();
    vga_1bit_scanout_if fb ();
    assign fb.fifo_q     = PAT;
    assign fb.fifo_empty = 1'b0;

    logic hs_a, vs_a, pix_a, vb_a, uf_a;
    logic hs_b, vs_b, pix_b, vb_b, uf_b;
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_a, ucnt_b;
`endif

    vga_1bit_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_a (
        .clk(clk), .reset(reset), .enable(enable), .fifo(fa),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_pixel(pix_a),
        .vblank_start(vb_a), .underflow(uf_a)
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
        , .underflow_cnt(ucnt_a)
`endif
    );

    vga_1bit_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .enable(enable), .fifo(fb),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_pixel(pix_b),
        .vblank_start(vb_b), .underflow(uf_b)
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
        , .underflow_cnt(ucnt_b)
`endif
    );

    int tests = 0;
    int fails = 0;
    int n = 0;

    logic [15:0] fq[$];
    logic [15:0] mq[$];

    // Reference model state, indexed by DUT (0 = a, 1 = b)
    bit          m_run[2];
    int          m_t[2];
    int          m_ph[2];
    bit          m_uf[2];
    int          m_cnt[2];
    bit          m_enq[2];
    logic [15:0] m_word[2];
    bit          e_hs[2], e_vs[2], e_pix[2], e_rd[2], e_vb[2];

    int n_vb_a, n_rd_a, n_pix_a;
    int hist_n;
    logic b_pix_hist[8];
    logic b_rd_hist[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic fifo_sync();
        fa.fifo_empty = (fq.size() == 0);
        fa.fifo_q     = (fq.size() != 0) ? fq[0] : 16'h0000;
    endtask

    task automatic push(logic [15:0] w);
        fq.push_back(w);
        mq.push_back(w);
        fifo_sync();
    endtask

    task automatic clr_fifo();
        fq.delete();
        mq.delete();
        fifo_sync();
    endtask

    // Predicts the outputs after the coming edge from pixel time within the frame
    task automatic model_step(int k);
        int div, h, v;
        bit pe, emp;
        logic [15:0] head;
        div = (k == 0) ? 1 : 2;
        if (k == 0) begin
            emp  = (mq.size() == 0);
            head = emp ? 16'h0000 : mq[0];
        end else begin
            emp  = 1'b0;
            head = PAT;
        end
        if (reset) begin
            m_run[k] = 0; m_t[k] = 0; m_ph[k] = 0;
            m_uf[k] = 0; m_cnt[k] = 0; m_enq[k] = 0;
            m_word[k] = 16'h0000;
            e_hs[k] = 1; e_vs[k] = 1; e_pix[k] = 0;
            e_rd[k] = 0; e_vb[k] = 0;
        end else begin
            pe = (m_ph[k] == div - 1);
            m_ph[k] = pe ? 0 : m_ph[k] + 1;
            e_rd[k] = 0;
            e_vb[k] = 0;
            if (enable && !m_enq[k]) begin
                m_uf[k] = 0;
                m_cnt[k] = 0;
            end
            if (!m_run[k]) begin
                e_hs[k] = 1; e_vs[k] = 1; e_pix[k] = 0;
                m_t[k] = 0;
                if (enable) m_run[k] = 1;
            end else if (pe) begin
                h = m_t[k] % HT;
                v = m_t[k] / HT;
                e_hs[k] = !(h >= HA + HF && h < HA + HF + HSY);
                e_vs[k] = !(v >= VA + VF && v < VA + VF + VSY);
                e_vb[k] = (v == VA && h == 0);
                if (h < HA && v < VA) begin
                    if (h % 16 == 0) begin
                        if (emp) begin
                            m_word[k] = 16'h0000;
                            m_uf[k] = 1;
                            if (m_cnt[k] < 65535) m_cnt[k]++;
                        end else begin
                            m_word[k] = head;
                            e_rd[k] = 1;
                            if (k == 0) void'(mq.pop_front());
                        end
                    end
                    e_pix[k] = m_word[k][15 - (h % 16)];
                end else begin
                    e_pix[k] = 0;
                end
                if (m_t[k] == FT - 1) begin
                    m_t[k] = 0;
                    if (!enable) m_run[k] = 0;
                end else begin
                    m_t[k]++;
                end
            end
            m_enq[k] = enable;
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        if (fa.fifo_rdreq === 1'b1 && fq.size() != 0) begin
            void'(fq.pop_front());
            fifo_sync();
        end
        chk("a_hs", 32'(hs_a), 32'(e_hs[0]));
        chk("a_vs", 32'(vs_a), 32'(e_vs[0]));
        chk("a_pixel", 32'(pix_a), 32'(e_pix[0]));
        chk("a_rdreq", 32'(fa.fifo_rdreq), 32'(e_rd[0]));
        chk("a_vblank", 32'(vb_a), 32'(e_vb[0]));
        chk("a_underflow", 32'(uf_a), 32'(m_uf[0]));
        chk("b_hs", 32'(hs_b), 32'(e_hs[1]));
        chk("b_vs", 32'(vs_b), 32'(e_vs[1]));
        chk("b_pixel", 32'(pix_b), 32'(e_pix[1]));
        chk("b_rdreq", 32'(fb.fifo_rdreq), 32'(e_rd[1]));
        chk("b_vblank", 32'(vb_b), 32'(e_vb[1]));
        chk("b_underflow", 32'(uf_b), 32'(m_uf[1]));
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
        chk("a_ucnt", 32'(ucnt_a), 32'(m_cnt[0]));
        chk("b_ucnt", 32'(ucnt_b), 32'(m_cnt[1]));
`endif
        n_vb_a  += int'(vb_a);
        n_rd_a  += int'(fa.fifo_rdreq);
        n_pix_a += int'(pix_a);
        if (hist_n < 8) begin
            b_pix_hist[hist_n] = pix_b;
            b_rd_hist[hist_n]  = fb.fifo_rdreq;
            hist_n++;
        end
        n++;
    endtask

    task automatic run_to(int target);
        while (n < target) tick();
    endtask

    initial begin
        vec_t tbl [21];
        logic [7:0] hold_pix;
        logic [7:0] hold_rd;
        tbl = '{
            '{0,  0, 1, 1, 1, 1, 0}, '{0,  1, 0, 1, 1, 0, 0},
            '{0,  2, 1, 1, 1, 0, 0}, '{0,  4, 0, 1, 1, 0, 0},
            '{0,  5, 1, 1, 1, 0, 0}, '{0,  8, 1, 1, 1, 0, 0},
            '{0, 12, 0, 1, 1, 0, 0}, '{0, 15, 0, 1, 1, 0, 0},
            '{0, 16, 1, 1, 1, 1, 0}, '{0, 31, 0, 1, 1, 0, 0},
            '{0, 32, 0, 1, 1, 0, 0}, '{0, 34, 0, 0, 1, 0, 0},
            '{0, 37, 0, 0, 1, 0, 0}, '{0, 38, 0, 1, 1, 0, 0},
            '{1,  0, 1, 1, 1, 1, 0}, '{3, 16, 1, 1, 1, 1, 0},
            '{4,  0, 0, 1, 1, 0, 1}, '{4,  1, 0, 1, 1, 0, 0},
            '{5,  0, 0, 1, 0, 0, 0}, '{6, 39, 0, 1, 0, 0, 0},
            '{7,  0, 0, 1, 1, 0, 0}
        };
        hold_pix = 8'b00110011;
        hold_rd  = 8'b00000001;
        hist_n = 8;
        n_vb_a = 0; n_rd_a = 0; n_pix_a = 0;

        reset = 1'b1;
        enable = 1'b1;
        clr_fifo();

        // Reset held with enable high
        repeat (3) tick();
        chk("rst_hs", 32'(hs_a), 32'd1);
        chk("rst_vs", 32'(vs_a), 32'd1);
        chk("rst_pixel", 32'(pix_a), 32'd0);
        chk("rst_rdreq", 32'(fa.fifo_rdreq), 32'd0);
        chk("rst_vblank", 32'(vb_a), 32'd0);
        chk("rst_underflow", 32'(uf_a), 32'd0);

        // Frame 0: eight preloaded words
        repeat (8) push(PAT);
        reset = 1'b0;
        tick();
        n = 0;
        hist_n = 0;
        n_vb_a = 0; n_rd_a = 0;
        foreach (tbl[i]) begin
            run_to(tbl[i].v * HT + tbl[i].h + 1);
            chk("tbl_pixel", 32'(pix_a), 32'(tbl[i].pix));
            chk("tbl_hs", 32'(hs_a), 32'(tbl[i].hs));
            chk("tbl_vs", 32'(vs_a), 32'(tbl[i].vs));
            chk("tbl_rdreq", 32'(fa.fifo_rdreq), 32'(tbl[i].rd));
            chk("tbl_vblank", 32'(vb_a), 32'(tbl[i].vb));
        end
        for (int i = 0; i < 8; i++) begin
            chk("b_hold_pixel", 32'(b_pix_hist[i]), 32'(hold_pix[i]));
            chk("b_hold_rdreq", 32'(b_rd_hist[i]), 32'(hold_rd[i]));
        end
        run_to(FT);
        chk("f0_vblank_pulses", 32'(n_vb_a), 32'd1);
        chk("f0_pops", 32'(n_rd_a), 32'd8);
        chk("f0_underflow", 32'(uf_a), 32'd0);

        // Frame 1: FIFO empty throughout
        n_rd_a = 0; n_pix_a = 0; n_vb_a = 0;
        run_to(2 * FT);
        chk("f1_pops", 32'(n_rd_a), 32'd0);
        chk("f1_pixels", 32'(n_pix_a), 32'd0);
        chk("f1_underflow", 32'(uf_a), 32'd1);
        chk("f1_vblank_pulses", 32'(n_vb_a), 32'd1);
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
        chk("f1_ucnt", 32'(ucnt_a), 32'd8);
`endif

        // Frame 2: enable drops at v_cnt=2, frame still completes
        run_to(2 * FT + 2 * HT);
        enable = 1'b0;
        run_to(2 * FT + 5 * HT + 1);
        chk("drop_vs_active", 32'(vs_a), 32'd0);
        run_to(3 * FT);
        n_rd_a = 0;
        run_to(3 * FT + 20);
        chk("idle_hs", 32'(hs_a), 32'd1);
        chk("idle_vs", 32'(vs_a), 32'd1);
        chk("idle_pixel", 32'(pix_a), 32'd0);
        chk("idle_pops", 32'(n_rd_a), 32'd0);
        chk("idle_underflow_kept", 32'(uf_a), 32'd1);
        run_to(1300);
        enable = 1'b1;
        tick();
        chk("rise_clears_underflow", 32'(uf_a), 32'd0);

        // Reset on the h_cnt=16 load of an active line
        reset = 1'b1;
        tick();
        clr_fifo();
        repeat (8) push(PAT);
        reset = 1'b0;
        tick();
        n = 0;
        run_to(16);
        reset = 1'b1;
        tick();
        chk("midrst_hs", 32'(hs_a), 32'd1);
        chk("midrst_pixel", 32'(pix_a), 32'd0);
        chk("midrst_rdreq", 32'(fa.fifo_rdreq), 32'd0);
        chk("midrst_fifo_level", 32'(fq.size()), 32'd7);
        tick();
        chk("midrst_fifo_level2", 32'(fq.size()), 32'd7);
        reset = 1'b0;

        // Random enable, fills, flushes and resets against the model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 99) < 35) begin
                int cnt;
                cnt = $urandom_range(1, 10);
                for (int j = 0; j < cnt; j++) push(16'($urandom));
            end
            if ($urandom_range(0, 9) == 0) clr_fifo();
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 120)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
